// File: rtl/alu_pkg.sv
// Shared definitions for the ALU flag register / condition evaluator:
// condition codes, flag bit positions and result-stage states.
package alu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/cond_decode.sv
// Purely combinational condition-code evaluator over {N,V,C,Z}.
module cond_decode
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] code,
  output logic       taken
);

  logic n, v, c, z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];

  always_comb begin
    // NOTE: default assignment first so every path drives taken and no latch is inferred.
    taken = 1'b0;
    case (cond_e'(code))
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_cond.sv
// Flag register with same-cycle forwarding and a one-entry condition result stage.
// Optional: define ALU_COND_CNT_EN to add the taken_cnt consumed-taken counter.
module alu_flag_cond
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_we,
  input  logic [3:0]  flag_nvcz,
  input  logic        cond_valid,
  input  logic [3:0]  cond_code,
  output logic        cond_ready,
  output logic        res_valid,
  output logic        res_taken,
  output logic [3:0]  res_code,
  input  logic        res_ready,
  output logic [3:0]  flags_q
`ifdef ALU_COND_CNT_EN
  , output logic [15:0] taken_cnt
`endif
);

  state_e     state_q, state_d;
  logic [3:0] eff_flags;
  logic       taken_d;
  logic       accept;

  // A flag write in the same cycle as a request is visible to that request.
  assign eff_flags = flag_we ? flag_nvcz : flags_q;

  cond_decode u_cond_decode (
    .flags (eff_flags),
    .code  (cond_code),
    .taken (taken_d)
  );

  assign cond_ready = (state_q == ST_EMPTY) | res_ready;
  assign accept     = cond_valid & cond_ready;
  assign res_valid  = (state_q == ST_FULL);

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = ST_FULL;
    else if ((state_q == ST_FULL) && res_ready)
      state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q   <= ST_EMPTY;
      res_taken <= 1'b0;
      res_code  <= 4'd0;
      flags_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (flag_we)
        flags_q <= flag_nvcz;
      // Result is captured only on accept, so later flag writes cannot disturb it.
      if (accept) begin
        res_taken <= taken_d;
        res_code  <= cond_code;
      end
    end
  end

`ifdef ALU_COND_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      taken_cnt <= 16'd0;
    else if (res_valid && res_ready && res_taken)
      taken_cnt <= taken_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_flag_cond.sv
// Self-checking bench for alu_flag_cond: vector table, directed corner sequences
// and a cycle-level scoreboard monitor.
module tb_alu_flag_cond;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_we;
  logic [3:0]  flag_nvcz;
  logic        cond_valid;
  logic [3:0]  cond_code;
  logic        cond_ready;
  logic        res_valid;
  logic        res_taken;
  logic [3:0]  res_code;
  logic        res_ready;
  logic [3:0]  flags_q;
`ifdef ALU_COND_CNT_EN
  logic [15:0] taken_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_flag_cond dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .flag_nvcz  (flag_nvcz),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_ready (cond_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_code   (res_code),
    .res_ready  (res_ready),
    .flags_q    (flags_q)
`ifdef ALU_COND_CNT_EN
    , .taken_cnt (taken_cnt)
`endif
  );

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model written as base condition + invert-on-odd-code.
  function automatic logic model_cond(input logic [3:0] f, input logic [3:0] code);
    logic n, v, c, z, base;
    n = f[3]; v = f[2]; c = f[1]; z = f[0];
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return code[0] ? ~base : base;
  endfunction

  typedef struct {
    logic       taken;
    logic [3:0] code;
  } exp_t;

  exp_t        sb[$];
  logic        mon_en = 1'b0;
  logic        m_full;
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;

  // Monitor: inputs are stable between posedge+1 and the next posedge, so the
  // values seen at negedge are exactly what the next edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      logic acc;
      logic [3:0] eff;
      check("mon_res_valid", {15'd0, res_valid}, {15'd0, m_full});
      check("mon_cond_ready", {15'd0, cond_ready}, {15'd0, (!m_full || res_ready)});
      check("mon_flags_q", {12'd0, flags_q}, {12'd0, m_flags});
`ifdef ALU_COND_CNT_EN
      check("mon_taken_cnt", taken_cnt, m_cnt);
`endif
      if (m_full) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon_sb: result valid with empty scoreboard (t=%0t)", $time);
        end else begin
          check("mon_res_taken", {15'd0, res_taken}, {15'd0, sb[0].taken});
          check("mon_res_code", {12'd0, res_code}, {12'd0, sb[0].code});
        end
      end
      if (rst) begin
        m_full  = 1'b0;
        m_flags = 4'd0;
        m_cnt   = 16'd0;
        sb.delete();
      end else begin
        acc = cond_valid && (!m_full || res_ready);
        eff = flag_we ? flag_nvcz : m_flags;
        if (m_full && res_ready && sb.size() != 0) begin
          if (sb[0].taken) m_cnt = m_cnt + 16'd1;
          void'(sb.pop_front());
        end
        if (acc) sb.push_back('{taken: model_cond(eff, cond_code), code: cond_code});
        m_full = acc || (m_full && !res_ready);
        if (flag_we) m_flags = flag_nvcz;
      end
    end
  end

  typedef struct {
    logic [3:0] nvcz;
    logic [3:0] code;
    logic       taken;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] stream_exp;
    rst = 1'b1; flag_we = 1'b0; flag_nvcz = 4'd0;
    cond_valid = 1'b0; cond_code = 4'd0; res_ready = 1'b0;
    m_full = 1'b0; m_flags = 4'd0; m_cnt = 16'd0;

    vecs = '{
      '{4'b0001, 4'd0,  1'b1}, '{4'b0000, 4'd0,  1'b0}, '{4'b0000, 4'd1,  1'b1},
      '{4'b0010, 4'd2,  1'b1}, '{4'b0010, 4'd3,  1'b0}, '{4'b1000, 4'd4,  1'b1},
      '{4'b1000, 4'd5,  1'b0}, '{4'b0100, 4'd6,  1'b1}, '{4'b0100, 4'd7,  1'b0},
      '{4'b0010, 4'd8,  1'b1}, '{4'b0011, 4'd8,  1'b0}, '{4'b0011, 4'd9,  1'b1},
      '{4'b1100, 4'd10, 1'b1}, '{4'b1100, 4'd11, 1'b0}, '{4'b1100, 4'd12, 1'b1},
      '{4'b1000, 4'd10, 1'b0}, '{4'b1000, 4'd13, 1'b1}, '{4'b1101, 4'd12, 1'b0},
      '{4'b0100, 4'd11, 1'b1}, '{4'b0000, 4'd14, 1'b1}, '{4'b1111, 4'd15, 1'b0}
    };

    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_res_valid", {15'd0, res_valid}, 16'd0);
    check("rst_res_taken", {15'd0, res_taken}, 16'd0);
    check("rst_res_code", {12'd0, res_code}, 16'd0);
    check("rst_flags_q", {12'd0, flags_q}, 16'd0);
    check("rst_cond_ready", {15'd0, cond_ready}, 16'd1);

    // Flag write, then EQ request the following cycle.
    flag_we = 1'b1; flag_nvcz = 4'b0001;
    tick();
    flag_we = 1'b0; cond_valid = 1'b1; cond_code = 4'd0;
    tick();
    cond_valid = 1'b0;
    check("eq_res_valid", {15'd0, res_valid}, 16'd1);
    check("eq_res_taken", {15'd0, res_taken}, 16'd1);
    check("eq_res_code", {12'd0, res_code}, 16'd0);

    // Backpressure: result must hold while flags keep changing.
    cond_valid = 1'b1; cond_code = 4'd1;
    for (int k = 0; k < 3; k++) begin
      flag_we = 1'b1; flag_nvcz = 4'($urandom_range(0, 15));
      tick();
      check("bp_cond_ready", {15'd0, cond_ready}, 16'd0);
      check("bp_res_valid", {15'd0, res_valid}, 16'd1);
      check("bp_res_taken", {15'd0, res_taken}, 16'd1);
      check("bp_res_code", {12'd0, res_code}, 16'd0);
    end
    flag_we = 1'b0; cond_valid = 1'b0; res_ready = 1'b1;
    tick();
    check("bp_drain_valid", {15'd0, res_valid}, 16'd0);

    // Forwarding: flag write and MI request in the same cycle.
    flag_we = 1'b1; flag_nvcz = 4'b0000;
    tick();
    flag_nvcz = 4'b1000; cond_valid = 1'b1; cond_code = 4'd4;
    tick();
    flag_we = 1'b0; cond_valid = 1'b0;
    check("fwd_res_taken", {15'd0, res_taken}, 16'd1);
    check("fwd_res_code", {12'd0, res_code}, 16'd4);
    tick();

    // Decode table, one vector per cycle with forwarded flags.
    foreach (vecs[i]) begin
      flag_we = 1'b1; flag_nvcz = vecs[i].nvcz;
      cond_valid = 1'b1; cond_code = vecs[i].code;
      tick();
      check("tbl_res_valid", {15'd0, res_valid}, 16'd1);
      check("tbl_res_taken", {15'd0, res_taken}, {15'd0, vecs[i].taken});
      check("tbl_res_code", {12'd0, res_code}, {12'd0, vecs[i].code});
    end
    flag_we = 1'b0; cond_valid = 1'b0;
    tick();

    // Streaming codes 0..7 with flags V=1, Z=1.
    stream_exp = 8'b0110_1001;
    flag_we = 1'b1; flag_nvcz = 4'b0101; cond_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cond_code = 4'(i);
      tick();
      flag_we = 1'b0;
      check("str_res_valid", {15'd0, res_valid}, 16'd1);
      check("str_res_code", {12'd0, res_code}, 16'(i));
      check("str_res_taken", {15'd0, res_taken}, {15'd0, stream_exp[i]});
    end
    cond_valid = 1'b0;
    tick();

    // Reset while FULL, with a flag write and request in the reset cycle.
    res_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'd14;
    tick();
    check("rf_res_valid_pre", {15'd0, res_valid}, 16'd1);
    rst = 1'b1; flag_we = 1'b1; flag_nvcz = 4'b1111;
    tick();
    rst = 1'b0; flag_we = 1'b0; cond_valid = 1'b0;
    check("rf_res_valid", {15'd0, res_valid}, 16'd0);
    check("rf_flags_q", {12'd0, flags_q}, 16'd0);
    check("rf_cond_ready", {15'd0, cond_ready}, 16'd1);
    check("rf_res_taken", {15'd0, res_taken}, 16'd0);
`ifdef ALU_COND_CNT_EN
    check("rf_taken_cnt", taken_cnt, 16'd0);
`endif
    tick();
    tick();
    check("sb_drain", 16'(sb.size()), 16'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_cond.md
ALU_FLAG_COND -- requirements
Module: alu_flag_cond

Interface
- REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
- REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
- REQ-003 SHALL have port flag_we, input, 1, loads flag register from flag_nvcz.
- REQ-004 SHALL have port flag_nvcz, input, 4, {N,V,C,Z} from ALU status outputs.
- REQ-005 SHALL have port cond_valid, input, 1, condition request valid.
- REQ-006 SHALL have port cond_code, input, 4, condition code to evaluate.
- REQ-007 SHALL have port cond_ready, output, 1, request accepted when cond_valid&cond_ready.
- REQ-008 SHALL have port res_valid, output, 1, result valid.
- REQ-009 SHALL have port res_taken, output, 1, condition outcome.
- REQ-010 SHALL have port res_code, output, 4, cond_code of the accepted request.
- REQ-011 SHALL have port res_ready, input, 1, consumer accepts result when res_valid&res_ready.
- REQ-012 SHALL have port flags_q, output, 4, current flag register {N,V,C,Z}.

Function
- REQ-013 SHALL update flags_q <= flag_nvcz on each clk edge with flag_we=1; hold otherwise.
- REQ-014 SHALL evaluate conditions on effective flags = flag_we ? flag_nvcz : flags_q (same-cycle forwarding).
- REQ-015 SHALL decode: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- REQ-016 SHALL implement a two-state FSM, EMPTY (res_valid=0) and FULL (res_valid=1).
- REQ-017 SHALL drive cond_ready = (state==EMPTY) | res_ready, combinationally.
- REQ-018 SHALL, on accept, register res_taken and res_code and be FULL next cycle: latency exactly 1 cycle.
- REQ-019 SHALL, in FULL with res_ready=1 and accept, load the new result (back-to-back, 1 result/cycle).
- REQ-020 SHALL, in FULL with res_ready=1 and no accept, go EMPTY.
- REQ-021 SHALL hold res_taken/res_code stable while FULL and res_ready=0, even if flag_we changes flags.
- REQ-022 SHALL not let a flag write after acceptance alter an already registered result.

Reset
- REQ-023 SHALL, when rst=1 at a clk edge, set state EMPTY, res_valid=0, res_taken=0, res_code=0, flags_q=4'b0000, overriding flag_we and any accept that cycle.
- REQ-024 SHALL drop any pending result on reset mid-operation; cond_ready=1 the cycle after reset.

Configuration
- REQ-025 SHALL, with ALU_COND_CNT_EN defined, add output taken_cnt[15:0] counting results consumed (res_valid&res_ready) with res_taken=1, wrapping 0xFFFF->0x0000, reset to 0.
- REQ-026 SHALL, without ALU_COND_CNT_EN, omit taken_cnt port and counter entirely; all other behaviour identical.

Structure
- REQ-027 SHALL place condition-code constants (COND_EQ..COND_NV) and flag bit indices (FLAG_N=3, FLAG_V=2, FLAG_C=1, FLAG_Z=0) in shared package alu_pkg.
- REQ-028 SHALL isolate condition decoding in combinational sub-module cond_decode (flags[3:0], code[3:0] -> taken).

Verification
- REQ-029 SHALL test: flag_we with nvcz=4'b0001, next cycle request EQ -> one cycle later res_valid=1, res_taken=1, res_code=0.
- REQ-030 SHALL test forwarding: flags_q=0000, same cycle flag_we nvcz=1000 and request MI -> res_taken=1.
- REQ-031 SHALL test signed compare: nvcz=1100 -> GE=1, LT=0, GT=1; nvcz=1000 -> GE=0, LE=1.
- REQ-032 SHALL test backpressure: res_ready=0 three cycles after accept -> cond_ready=0, res outputs stable, flag writes ignored by result; res_ready=1 -> EMPTY.
- REQ-033 SHALL test streaming: res_ready=1, cond_valid=1 for 8 cycles codes 0..7 -> 8 results on consecutive cycles, in order.
- REQ-034 SHALL test reset in FULL: rst=1 -> res_valid=0, flags_q=0000, taken_cnt=0 (if ALU_COND_CNT_EN).
